// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: hazard/event requests into the sequencer, stage
// enables, flush controls and perf counters out of it.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             hazard_stall;
  logic             ex_redirect;
  logic             ex_md_start;
  logic             mem_busy;
  logic             PC_En;
  logic             IF_ID_En;
  logic             ID_EX_En;
  logic             EX_MEM_En;
  logic             MEM_WB_En;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic             EX_MEM_Flush;
  logic             md_done;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] redirect_count;

  modport master (
    output hazard_stall, ex_redirect, ex_md_start, mem_busy,
    input  PC_En, IF_ID_En, ID_EX_En, EX_MEM_En, MEM_WB_En,
    input  IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, md_done,
    input  stall_cycles, redirect_count
  );

  modport slave (
    input  hazard_stall, ex_redirect, ex_md_start, mem_busy,
    output PC_En, IF_ID_En, ID_EX_En, EX_MEM_En, MEM_WB_En,
    output IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, md_done,
    output stall_cycles, redirect_count
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central 5-stage pipeline sequencer: reset flush, mul/div occupancy, mem wait,
// redirect and RAW stall. Optional perf counters under PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int MD_LATENCY       = 32,
  parameter int RST_FLUSH_CYCLES = 2,
  parameter int CNT_W            = 32
) (
  input  logic      clk,
  input  logic      rst,
  pipe_ctrl_if.slave pif
);
  // state     | meaning
  // RST_FLUSH | front end held, all pipeline registers loaded with bubbles
  // RUN       | normal issue; mem wait / mul/div / redirect / RAW by priority
  // MD_BUSY   | mul/div occupies EX; front end frozen, bubbles sent to MEM
  // MD_DONE   | EX result mux selects mul/div result; retire and resume
  localparam logic [1:0] ST_RST_FLUSH = 2'd0;
  localparam logic [1:0] ST_RUN       = 2'd1;
  localparam logic [1:0] ST_MD_BUSY   = 2'd2;
  localparam logic [1:0] ST_MD_DONE   = 2'd3;

  localparam int FLUSH_W = (RST_FLUSH_CYCLES > 1) ? $clog2(RST_FLUSH_CYCLES) : 1;
  localparam int MD_W    = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
  localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(RST_FLUSH_CYCLES - 1);
  localparam logic [MD_W-1:0]    MD_INIT    = MD_W'(MD_LATENCY - 1);

  logic [1:0]         state_q, state_d;
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [MD_W-1:0]    md_cnt_q, md_cnt_d;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, md_done;

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    md_cnt_d     = md_cnt_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    md_done      = 1'b0;
    case (state_q)
      ST_RST_FLUSH: begin
        pc_en        = 1'b0;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        if (flush_cnt_q == '0) state_d = ST_RUN;
        else                   flush_cnt_d = flush_cnt_q - 1'b1;
      end
      ST_RUN: begin
        if (pif.mem_busy) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
        end else if (pif.ex_md_start) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_flush = 1'b1;
          state_d      = ST_MD_BUSY;
          md_cnt_d     = MD_INIT;
        end else if (pif.ex_redirect) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (pif.hazard_stall) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      ST_MD_BUSY: begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_flush = 1'b1;
        if (pif.mem_busy) begin
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
        end
        // The unit keeps computing while MEM waits, so the count never pauses.
        if (md_cnt_q == '0) state_d = ST_MD_DONE;
        else                md_cnt_d = md_cnt_q - 1'b1;
      end
      ST_MD_DONE: begin
        md_done = 1'b1;
        if (pif.mem_busy) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
        end else begin
          state_d = ST_RUN;
          if (pif.ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (pif.hazard_stall) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
      end
      default: state_d = ST_RST_FLUSH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RST_FLUSH;
      flush_cnt_q <= FLUSH_INIT;
      md_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      md_cnt_q    <= md_cnt_d;
    end
  end

  assign pif.PC_En        = pc_en;
  assign pif.IF_ID_En     = if_id_en;
  assign pif.ID_EX_En     = id_ex_en;
  assign pif.EX_MEM_En    = ex_mem_en;
  assign pif.MEM_WB_En    = mem_wb_en;
  assign pif.IF_ID_Flush  = if_id_flush;
  assign pif.ID_EX_Flush  = id_ex_flush;
  assign pif.EX_MEM_Flush = ex_mem_flush;
  assign pif.md_done      = md_done;

`ifdef PIPE_CTRL_PERF_EN
  logic             redir_apply;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] redirect_count_q, redirect_count_d;

  assign redir_apply = pif.ex_redirect && !pif.mem_busy &&
                       ((state_q == ST_RUN && !pif.ex_md_start) || state_q == ST_MD_DONE);

  always_comb begin
    stall_cycles_d   = stall_cycles_q;
    redirect_count_d = redirect_count_q;
    if (state_q != ST_RST_FLUSH && !pc_en && stall_cycles_q != '1)
      stall_cycles_d = stall_cycles_q + 1'b1;
    if (redir_apply && redirect_count_q != '1)
      redirect_count_d = redirect_count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q   <= '0;
      redirect_count_q <= '0;
    end else begin
      stall_cycles_q   <= stall_cycles_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign pif.stall_cycles   = stall_cycles_q;
  assign pif.redirect_count = redirect_count_q;
`else
  assign pif.stall_cycles   = '0;
  assign pif.redirect_count = '0;
`endif
endmodule
